// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   BYTE_W         - width of one transmitted byte
//   feeder_state_t - load sequencer states of uart_tx_feeder
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x BYTE_W register array, one write port, one
// combinational read port.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Storage is not reset; validity is tracked by the owner's pointers/count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus load sequencer feeding a UART transmitter
// over the ld_tx_data / tx_data / tx_empty handshake.
//   txclk, reset     - clock, synchronous active-high reset
//   wr_en, wr_data   - host push
//   full, fifo_empty - occupancy flags (combinational from count)
//   count            - occupancy 0..DEPTH
//   overflow/clr_ovf - sticky dropped-push flag and its clear
//   ld_tx_data       - one-cycle load strobe, tx_data valid with it
//   tx_empty         - transmitter ready
//   busy             - sequencer not idle
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              txclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              ld_tx_data,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_empty,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    feeder_state_t     state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;

    logic              push;
    logic              pop;
    logic              drop;
    logic [BYTE_W-1:0] rd_data;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (txclk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign full       = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == CNT_W'(0));

    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push = wr_en && !full;
    assign drop = wr_en && full;
    assign pop  = (state_q == IDLE) && !fifo_empty && tx_empty;

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            tx_data_d = rd_data;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        // tx_empty is deliberately not looked at in LOAD.
        case (state_q)
            IDLE:      if (pop)       state_d = LOAD;
            LOAD:                     state_d = WAIT_ACK;
            WAIT_ACK:  if (!tx_empty) state_d = WAIT_DONE;
            WAIT_DONE: if (tx_empty)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Moore outputs decoded from the state register.
    assign ld_tx_data = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_data    = tx_data_q;

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed self-checking bench for uart_tx_feeder with a
// byte scoreboard and a behavioural transmitter model.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int          FRAME  = 10;

    logic              txclk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              fifo_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;
    logic              ld_tx_data;
    logic [7:0]        tx_data;
    logic              tx_empty;
    logic              busy;

    logic              model_on = 1'b0;
    logic              model_te = 1'b1;
    logic              tb_te    = 1'b1;
    int                mcnt     = 0;

    int                errors   = 0;
    int                checks   = 0;
    int                strobes  = 0;
    int                cyc      = 0;
    logic              prev_ld  = 1'b0;
    logic [7:0]        exp_q [$];
    int                strobe_cyc [$];

    always #5 txclk = ~txclk;
    always @(posedge txclk) cyc++;

    assign tx_empty = model_on ? model_te : tb_te;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .txclk      (txclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .fifo_empty (fifo_empty),
        .count      (count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for FRAME cycles after each captured load.
    always @(negedge txclk) begin
        if (!model_on) begin
            mcnt     = 0;
            model_te = 1'b1;
        end else if (mcnt > 0) begin
            mcnt--;
            model_te = (mcnt == 0);
        end else if (ld_tx_data === 1'b1) begin
            mcnt     = FRAME;
            model_te = 1'b0;
        end
    end

    // Scoreboard: every strobe must match the oldest expected byte.
    always @(negedge txclk) begin
        if (ld_tx_data === 1'b1) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            chk("ld_one_cycle", 32'(prev_ld), 32'd0);
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_ld = ld_tx_data;
    end

    task automatic step(input int n);
        repeat (n) @(negedge txclk);
    endtask

    task automatic push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(count == 0 && busy == 1'b0) && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(count == 0 && busy == 1'b0), 32'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ld_tx_data", 32'(ld_tx_data), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int s0;
        int last;
        int seq [$];

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        chk_reset_values();

        // Single byte: strobe one cycle after the push edge.
        push(8'hA5, 1'b1);
        chk("single_count_after_push", 32'(count), 32'd1);
        chk("single_no_ld_yet", 32'(ld_tx_data), 32'd0);
        step(1);
        chk("single_ld", 32'(ld_tx_data), 32'd1);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        chk("single_count_popped", 32'(count), 32'd0);
        tb_te = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) begin
            chk("single_busy_hold", 32'(busy), 32'd1);
            chk("single_no_restrobe", 32'(ld_tx_data), 32'd0);
            step(1);
        end
        chk("single_tx_data_held", 32'(tx_data), 32'hA5);
        tb_te = 1'b1;
        step(1);
        chk("single_busy_release", 32'(busy), 32'd0);

        // Back-pressure: three bytes, transmitter busy FRAME cycles each.
        tb_te = 1'b0;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        chk("bp_count_3", 32'(count), 32'd3);
        s0   = strobes;
        last = int'(count);
        seq.push_back(last);
        model_on = 1'b1;
        for (int n = 0; n < 300 && !(count == 0 && busy == 1'b0); n++) begin
            step(1);
            if (int'(count) != last) begin
                last = int'(count);
                seq.push_back(last);
            end
        end
        chk("bp_drained", 32'(count == 0 && busy == 1'b0), 32'd1);
        chk("bp_strobes", 32'(strobes - s0), 32'd3);
        chk("bp_count_steps", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            chk("bp_count_value", 32'(seq[i]), 32'(3 - i));
        end
        for (int i = strobe_cyc.size() - 2; i < strobe_cyc.size(); i++) begin
            chk("bp_strobe_gap", 32'(strobe_cyc[i] - strobe_cyc[i-1] >= FRAME + 2), 32'd1);
        end
        model_on = 1'b0;
        step(1);

        // Fill and overflow.
        tb_te = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(8'h40 + 8'(i), i < DEPTH);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'(DEPTH));
        chk("fill_fifo_empty", 32'(fifo_empty), 32'd0);
        chk("fill_overflow", 32'(overflow), 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        step(1);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        chk("fill_count_kept", 32'(count), 32'(DEPTH));
        s0 = strobes;
        model_on = 1'b1;
        wait_idle("fill_drain_timeout", DEPTH * (FRAME + 4) + 50);
        chk("fill_strobes", 32'(strobes - s0), 32'(DEPTH));
        chk("fill_queue_empty", 32'(exp_q.size()), 32'd0);
        model_on = 1'b0;
        step(1);

        // Simultaneous push and pop on the IDLE->LOAD edge.
        tb_te = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        chk("simul_count_pre", 32'(count), 32'd2);
        tb_te   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h33;
        exp_q.push_back(8'h33);
        step(1);
        wr_en = 1'b0;
        chk("simul_count", 32'(count), 32'd2);
        chk("simul_ld", 32'(ld_tx_data), 32'd1);
        tb_te = 1'b0;
        step(3);
        model_on = 1'b1;
        wait_idle("simul_drain_timeout", 3 * (FRAME + 4) + 50);
        chk("simul_queue_empty", 32'(exp_q.size()), 32'd0);
        model_on = 1'b0;
        step(1);

        // Pointer wrap: 3*DEPTH incrementing bytes in half-depth bursts.
        s0 = strobes;
        model_on = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < DEPTH / 2; k++) begin
                push(8'h80 + 8'(b * (DEPTH / 2) + k), 1'b1);
            end
            wait_idle("wrap_drain_timeout", (DEPTH / 2) * (FRAME + 4) + 50);
        end
        chk("wrap_strobes", 32'(strobes - s0), 32'(3 * DEPTH));
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
        model_on = 1'b0;
        step(1);

        // Reset while in WAIT_DONE with 5 entries queued.
        tb_te = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(8'hC0 + 8'(i), 1'b1);
        end
        tb_te = 1'b1;
        step(1);
        tb_te = 1'b0;
        step(2);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_count", 32'(count), 32'd5);
        reset = 1'b1;
        exp_q.delete();
        step(1);
        reset = 1'b0;
        chk_reset_values();
        tb_te = 1'b1;
        s0 = strobes;
        step(20);
        chk("post_rst_no_strobe", 32'(strobes - s0), 32'd0);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        model_on = 1'b1;
        push(8'h5A, 1'b1);
        wait_idle("post_rst_drain_timeout", FRAME + 50);
        chk("post_rst_one_strobe", 32'(strobes - s0), 32'd1);
        chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
        model_on = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_feeder

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO plus load sequencer sitting directly upstream of the UART transmitter, in the `txclk` domain. The host pushes bytes at any rate up to one per clock. The block buffers them and hands them to the transmitter one at a time over the transmitter's `ld_tx_data` / `tx_data` / `tx_empty` handshake. It guarantees exactly one load pulse per byte, and never loads while the transmitter is busy.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `ADDR_W`, $clog2(DEPTH): pointer width; derived, not overridden.
- `txclk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `wr_en` in 1: host push request.
- `wr_data` in 8: host byte.
- `full` out 1: FIFO holds DEPTH entries.
- `fifo_empty` out 1: FIFO holds 0 entries.
- `count` out ADDR_W+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky flag; a push was dropped.
- `clr_ovf` in 1: clears `overflow`.
- `ld_tx_data` out 1: one-cycle load strobe to the transmitter.
- `tx_data` out 8: byte presented with `ld_tx_data`.
- `tx_empty` in 1: transmitter idle/ready flag; 1 = can accept a byte.
- `busy` out 1: sequencer not in IDLE.

## Operation
- Push: `wr_en && !full` writes `wr_data` at `wr_ptr` and increments `wr_ptr` (mod DEPTH).
- A push with `wr_en && full` is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
- `overflow` clears on `clr_ovf`. If `clr_ovf` and a dropped push occur in the same cycle, set wins.
- Pop happens only on the IDLE->LOAD transition: `tx_data <= mem[rd_ptr]`, then `rd_ptr++`.
- `count` follows the push and pop results:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- `full` = (count == DEPTH); `fifo_empty` = (count == 0). Both are combinational from `count`.
- The sequencer FSM has four states: IDLE, LOAD, WAIT_ACK, WAIT_DONE.
  - IDLE: when `!fifo_empty && tx_empty`, pop and go to LOAD.
  - LOAD: `ld_tx_data` = 1 for exactly this one cycle; go to WAIT_ACK.
  - WAIT_ACK: stay until `tx_empty == 0`, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_empty == 1`, then go to IDLE.
- There is no timeout. If the transmitter is disabled, the sequencer stays in WAIT_DONE indefinitely.
- `ld_tx_data` and `busy` are Moore outputs decoded from the state register.
- `tx_data` holds its value from LOAD until the next pop.
- There is no bypass path: a byte written while the FIFO is empty still passes through storage.

## Timing
- Reset values:
  - count 0, full 0, fifo_empty 1, overflow 0
  - ld_tx_data 0, tx_data 8'h00, busy 0
  - state IDLE; both pointers 0
- A reset mid-operation discards all FIFO contents and abandons any load in progress.
- Latency, with an empty FIFO and `tx_empty` = 1:
  - The push is accepted at edge E0.
  - The FSM enters LOAD at E1.
  - `ld_tx_data` is high during the E1..E2 cycle; the transmitter captures at E2.
- Per-byte turnaround: at least 4 cycles between consecutive load strobes, plus the transmitter's frame time.
- `tx_empty` is sampled only in IDLE, WAIT_ACK and WAIT_DONE. Its value during LOAD is ignored.
- Pointers wrap silently at DEPTH-1 -> 0. Full and empty are distinguished by `count`, not by pointer equality.

## Structure
- Shared package `uart_pkg` holds:
  - `BYTE_W` = 8
  - the enum `feeder_state_t` {IDLE, LOAD, WAIT_ACK, WAIT_DONE}
- One sub-module, `uart_fifo_mem`: a DEPTH x 8 register array with one write port and a combinational read port indexed by `rd_ptr`.
- Pointers, `count` and the FSM live in `uart_tx_feeder`.

## Test plan
- **Single byte:** after reset, push 8'hA5 with `tx_empty` held 1.
  - Expect `ld_tx_data` high for exactly one cycle, 1 cycle after the push edge, with `tx_data` = 8'hA5.
  - Then drop `tx_empty` one cycle later: `busy` holds until `tx_empty` returns to 1.
- **Back-pressure:** push 3 bytes (8'h01, 8'h02, 8'h03) while a behavioural UART model holds `tx_empty` = 0 for 10 cycles per byte.
  - Expect exactly 3 load strobes, in order, each only after `tx_empty` has risen.
  - `count` steps 3, 2, 1, 0.
- **Fill and overflow:** with `tx_empty` = 0, push DEPTH+2 bytes.
  - Expect `full` = 1 and `count` = DEPTH, and `overflow` = 1.
  - The first DEPTH bytes drain intact; the last 2 are never loaded.
  - Assert `clr_ovf`: `overflow` returns to 0.
- **Simultaneous push/pop:** with the FIFO holding 2 entries, push during the IDLE->LOAD transition cycle. Expect `count` to stay at 2.
- **Pointer wrap:** stream 3*DEPTH incrementing bytes through the FIFO. Expect byte-exact order on `tx_data` across the wraps.
- **Reset mid-operation:** assert `reset` for 1 cycle while in WAIT_DONE with 5 entries queued.
  - Expect all reset values on the next cycle.
  - No further strobes until a new push.
